sar_adc_ctrl: RTL

- Digital successive-approximation controller for the tile's analog front end (sample/hold, capacitive DAC, comparator on ua pins).
- Drives the sample switch and the DAC code; consumes the asynchronous comparator output.
- Produces a WIDTH-bit conversion result with a one-cycle done strobe for the digital side (uo_out / uio).

---
 rtl/sar_pkg.sv | 38 +++
 rtl/sar_adc_ctrl_sync_2ff.sv | 30 +++
 rtl/sar_adc_ctrl.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sar_pkg.sv
// Shared definitions for the SAR ADC controller and its helpers:
// controller state encoding, synchronizer depth and default geometry.
package sar_pkg;

  // Controller states. The encoding is fixed so that a waveform viewer
  // shows the same values on every build.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SAMPLE  = 2'd1,
    ST_CONVERT = 2'd2,
    ST_DONE    = 2'd3
  } sar_state_e;

  // Number of flops between an asynchronous analog-derived input and
  // the first logic that is allowed to look at it.
  localparam int SYNC_DEPTH = 2;

  // Default conversion geometry, reused by the top-level wrapper.
  localparam int DEF_WIDTH         = 8;
  localparam int DEF_SAMPLE_CYCLES = 4;
  localparam int DEF_SETTLE_CYCLES = 4;

  // Width of a down-counter that must hold (max(a, b) - 1).
  function automatic int cnt_width(input int a, input int b);
    int m;
    if (a > b) begin
      m = a;
    end else begin
      m = b;
    end
    if (m <= 1) begin
      return 1;
    end else begin
      return $clog2(m);
    end
  endfunction

endpackage : sar_pkg

// File: rtl/sar_adc_ctrl_sync_2ff.sv
// Generic multi-bit flop synchronizer for asynchronous analog-derived
// inputs (comparator outputs, level detectors). Each bit is synchronized
// independently, so only use WIDTH > 1 for unrelated single-bit signals,
// never for a multi-bit bus that must be captured coherently.
module sync_2ff
  import sar_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync
);

  // Stage 0 is the metastability catcher; the last stage feeds logic.
  logic [SYNC_DEPTH-1:0][WIDTH-1:0] r_chain;

  // Shift the raw input through the synchronizer chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[SYNC_DEPTH-2:0], i_async};
    end
  end

  assign o_sync = r_chain[SYNC_DEPTH-1];

endmodule : sync_2ff

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation controller for the tile's analog front end.
// Holds the sample switch closed, then walks the DAC code from MSB to LSB,
// keeping each trial bit for which the synchronized comparator reports
// Vin >= Vdac. A final cycle in CONVERT with no trial bit left copies the
// committed code into the result register together with the move to DONE.
// Every output is a flop fed from next-state values, so nothing reaches an
// output combinationally from cmp_in.
module sar_adc_ctrl
  import sar_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int SAMPLE_CYCLES = DEF_SAMPLE_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             cmp_in,
  output logic             sample,
  output logic [WIDTH-1:0] dac_code,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CNT_W = cnt_width(SAMPLE_CYCLES, SETTLE_CYCLES);

  localparam logic [CNT_W-1:0] SAMPLE_LOAD = CNT_W'(SAMPLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [WIDTH-1:0] TRIAL_MSB   = {1'b1, {(WIDTH-1){1'b0}}};

  // FSM state
  sar_state_e       r_state;
  sar_state_e       w_state_nxt;

  // Shared sample/settle down-counter and SAR registers
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [WIDTH-1:0] r_trial;
  logic [WIDTH-1:0] w_trial_nxt;
  logic [WIDTH-1:0] r_commit;
  logic [WIDTH-1:0] w_commit_nxt;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] w_result_nxt;

  // Registered outputs and their next values
  logic             r_sample;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_dac;
  logic             w_sample_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic [WIDTH-1:0] w_dac_nxt;

  // Decode helpers
  logic             w_cmp_s;
  logic             w_cnt_zero;
  logic             w_finish;

  // The comparator is asynchronous to clk; only the synchronized copy
  // takes part in any decision.
  sync_2ff #(
    .WIDTH (1)
  ) u_cmp_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (cmp_in),
    .o_sync  (w_cmp_s)
  );

  assign w_cnt_zero = (r_cnt == '0);
  // Trial register has shifted out past bit 0: all bits are decided.
  assign w_finish   = (r_trial == '0);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; abort only acts while a conversion is running.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_SAMPLE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SAMPLE: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (w_cnt_zero) begin
          w_state_nxt = ST_CONVERT;
        end else begin
          w_state_nxt = ST_SAMPLE;
        end
      end
      ST_CONVERT: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (w_finish) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_CONVERT;
        end
      end
      ST_DONE: begin
        if (start) begin
          w_state_nxt = ST_SAMPLE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Counter and SAR register updates for the coming edge.
  always_comb begin
    w_cnt_nxt    = r_cnt;
    w_trial_nxt  = r_trial;
    w_commit_nxt = r_commit;
    w_result_nxt = r_result;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_cnt_nxt = SAMPLE_LOAD;
        end else begin
          w_cnt_nxt = '0;
        end
      end
      ST_SAMPLE: begin
        if (abort) begin
          w_cnt_nxt = '0;
        end else if (w_cnt_zero) begin
          w_cnt_nxt    = SETTLE_LOAD;
          w_trial_nxt  = TRIAL_MSB;
          w_commit_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      ST_CONVERT: begin
        if (abort) begin
          // Drop the partial code; result keeps the last good value.
          w_cnt_nxt    = '0;
          w_trial_nxt  = '0;
          w_commit_nxt = '0;
        end else if (w_finish) begin
          w_cnt_nxt    = '0;
          w_result_nxt = r_commit;
        end else if (w_cnt_zero) begin
          // Decide the current bit, then move the trial one bit down.
          if (w_cmp_s) begin
            w_commit_nxt = r_commit | r_trial;
          end else begin
            w_commit_nxt = r_commit & ~r_trial;
          end
          w_trial_nxt = r_trial >> 1;
          w_cnt_nxt   = SETTLE_LOAD;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      default: begin
        w_cnt_nxt    = '0;
        w_trial_nxt  = '0;
        w_commit_nxt = '0;
      end
    endcase
  end

  // Output decode from the next state, so the output flops line up with
  // the state register instead of trailing it by a cycle.
  always_comb begin
    w_sample_nxt = 1'b0;
    w_busy_nxt   = 1'b0;
    w_done_nxt   = 1'b0;
    w_dac_nxt    = '0;
    case (w_state_nxt)
      ST_IDLE: begin
        w_busy_nxt = 1'b0;
      end
      ST_SAMPLE: begin
        w_sample_nxt = 1'b1;
        w_busy_nxt   = 1'b1;
      end
      ST_CONVERT: begin
        w_busy_nxt = 1'b1;
        w_dac_nxt  = w_commit_nxt | w_trial_nxt;
      end
      ST_DONE: begin
        w_done_nxt = 1'b1;
      end
      default: begin
        w_busy_nxt = 1'b0;
      end
    endcase
  end

  // Counter, SAR registers and output flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_trial  <= '0;
      r_commit <= '0;
      r_result <= '0;
      r_sample <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_dac    <= '0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_trial  <= w_trial_nxt;
      r_commit <= w_commit_nxt;
      r_result <= w_result_nxt;
      r_sample <= w_sample_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_dac    <= w_dac_nxt;
    end
  end

  assign sample   = r_sample;
  assign busy     = r_busy;
  assign done     = r_done;
  assign dac_code = r_dac;
  assign result   = r_result;

endmodule : sar_adc_ctrl
